// File: rtl/csi_bringup_seq_if.sv
// ---------------------------------------------------------------------------
// csi_bringup_seq_if
// Purpose : groups the sensor-side status inputs and the sequencer's control
//           and status outputs of csi_bringup_seq into one bundle.
// Signals :
//   init_done_n, init_done0_n    CCI init complete, active-low, per sensor bus
//   init_error_n, init_error0_n  CCI init error, active-low, per sensor bus
//   csi_raw_valid                CSI RX activity pulse
//   csi_checksum_good/err        CSI RX packet status pulses
//   cci_run                      high lets both CCI handlers run
//   csi_enable, csi_reset        CSI RX enable / active-high reset
//   stream_ok                    high while streaming
//   state, fault_code            current state, cause of most recent fault
//   fault_lock                   retries exhausted
//   pkt_good_cnt, pkt_err_cnt    statistics counters
// Modports: slave = sequencer side, master = environment side.
// ---------------------------------------------------------------------------
interface csi_bringup_seq_if;
   logic        init_done_n;
   logic        init_done0_n;
   logic        init_error_n;
   logic        init_error0_n;
   logic        csi_raw_valid;
   logic        csi_checksum_good;
   logic        csi_checksum_err;
   logic        cci_run;
   logic        csi_enable;
   logic        csi_reset;
   logic        stream_ok;
   logic [2:0]  state;
   logic [2:0]  fault_code;
   logic        fault_lock;
   logic [15:0] pkt_good_cnt;
   logic [15:0] pkt_err_cnt;

   modport slave (
      input  init_done_n, init_done0_n, init_error_n, init_error0_n,
      input  csi_raw_valid, csi_checksum_good, csi_checksum_err,
      output cci_run, csi_enable, csi_reset, stream_ok,
      output state, fault_code, fault_lock, pkt_good_cnt, pkt_err_cnt
   );

   modport master (
      output init_done_n, init_done0_n, init_error_n, init_error0_n,
      output csi_raw_valid, csi_checksum_good, csi_checksum_err,
      input  cci_run, csi_enable, csi_reset, stream_ok,
      input  state, fault_code, fault_lock, pkt_good_cnt, pkt_err_cnt
   );
endinterface

// File: rtl/csi_bringup_seq.sv
// ---------------------------------------------------------------------------
// csi_bringup_seq
// Purpose : brings up a CSI camera link. Runs the CCI init handlers, waits
//           for both sensor buses to report init complete, enables the CSI
//           receiver, watches for packet activity and checksum errors, and
//           recovers from faults a limited number of times before locking out.
// Ports   :
//   clk    single rising-edge clock
//   RST_N  synchronous active-low reset
//   bus    csi_bringup_seq_if.slave (status inputs, control/status outputs)
// Optional feature: define CSI_BRINGUP_STATS_EN to get saturating good/error
//   packet counters; without it pkt_good_cnt/pkt_err_cnt are tied to zero.
// ---------------------------------------------------------------------------
module csi_bringup_seq #(
   parameter logic [23:0] INIT_TIMEOUT   = 24'd12_000_000,
   parameter logic [23:0] STREAM_TIMEOUT = 24'd6_000_000,
   parameter logic [7:0]  ERR_LIMIT      = 8'd16,
   parameter logic [15:0] RECOVER_CYCLES = 16'd1024,
   parameter logic [3:0]  MAX_RETRIES    = 4'd3
) (
   input  logic               clk,
   input  logic               RST_N,
   csi_bringup_seq_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_CCI = 3'd1,
      ENABLE   = 3'd2,
      STREAM   = 3'd3,
      FAULT    = 3'd4,
      RECOVER  = 3'd5
   } state_t;

   state_t      r_state, w_nextState;
   logic [23:0] r_timer, w_timerNext;
   logic [7:0]  r_errCnt, w_errNext, w_errInc;
   logic [3:0]  r_retry, w_retryNext;
   logic [2:0]  r_faultCode, w_faultCodeNext, w_code;
   logic        r_lock, w_lockNext;
   logic        r_cciRun, r_csiEnable, r_csiReset, r_streamOk;
   logic        w_cciRun, w_csiEnable, w_csiReset, w_streamOk;
   logic        w_initDone, w_initErr, w_gapExpired;

   assign w_initDone   = ~bus.init_done_n & ~bus.init_done0_n;
   assign w_initErr    = ~bus.init_error_n | ~bus.init_error0_n;
   assign w_gapExpired = (r_timer == STREAM_TIMEOUT - 24'd1);
   assign w_errInc     = (r_errCnt == 8'hFF) ? 8'hFF : r_errCnt + 8'd1;

   // Next-state logic. One shared timer serves the init timeout, the
   // activity gap and the recover hold, because only one of them is live in
   // any state; it is cleared on every state change. A fault from any state
   // is collected as a code first, so the cause ordering inside a state is
   // decided in one place and the FAULT entry is written once at the end.
   // The control outputs are decoded from the next state so they can be
   // registered alongside the state itself and always match it.
   always_comb begin
      w_nextState     = r_state;
      w_timerNext     = r_timer;
      w_errNext       = r_errCnt;
      w_retryNext     = r_retry;
      w_faultCodeNext = r_faultCode;
      w_lockNext      = r_lock;
      w_code          = 3'd0;

      case (r_state)
         IDLE: begin
            w_nextState = WAIT_CCI;
            w_timerNext = 24'd0;
         end
         WAIT_CCI: begin
            if (w_initDone) begin
               w_nextState = ENABLE;
               w_timerNext = 24'd0;
            end else if (w_initErr) begin
               w_code = 3'd1;
            end else if (r_timer == INIT_TIMEOUT - 24'd1) begin
               w_code = 3'd2;
            end else begin
               w_timerNext = r_timer + 24'd1;
            end
         end
         ENABLE: begin
            if (bus.csi_raw_valid) begin
               w_nextState = STREAM;
               w_timerNext = 24'd0;
               w_retryNext = 4'd0;
               w_errNext   = 8'd0;
            end else if (w_gapExpired) begin
               w_code = 3'd3;
            end else begin
               w_timerNext = r_timer + 24'd1;
            end
         end
         STREAM: begin
            if (bus.csi_checksum_err) begin
               w_errNext = w_errInc;
            end else if (bus.csi_checksum_good) begin
               w_errNext = 8'd0;
            end
            if (w_errNext == ERR_LIMIT) begin
               w_code = 3'd4;
            end else if (bus.csi_raw_valid) begin
               w_timerNext = 24'd0;
            end else if (w_gapExpired) begin
               w_code = 3'd3;
            end else begin
               w_timerNext = r_timer + 24'd1;
            end
         end
         FAULT: begin
            if (r_retry == MAX_RETRIES) begin
               w_lockNext = 1'b1;
            end else begin
               w_retryNext = r_retry + 4'd1;
               w_nextState = RECOVER;
               w_timerNext = 24'd0;
            end
         end
         RECOVER: begin
            if (r_timer == {8'd0, RECOVER_CYCLES} - 24'd1) begin
               w_nextState = WAIT_CCI;
               w_timerNext = 24'd0;
            end else begin
               w_timerNext = r_timer + 24'd1;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_timerNext = 24'd0;
         end
      endcase

      if (w_code != 3'd0) begin
         w_nextState     = FAULT;
         w_faultCodeNext = w_code;
         w_timerNext     = 24'd0;
      end

      w_cciRun    = (w_nextState == WAIT_CCI) || (w_nextState == ENABLE) ||
                    (w_nextState == STREAM);
      w_csiEnable = (w_nextState == ENABLE) || (w_nextState == STREAM);
      w_csiReset  = !w_csiEnable;
      w_streamOk  = (w_nextState == STREAM);
   end

   // State register plus all registered outputs. Reset is synchronous and
   // wins in every state, including a locked FAULT or the middle of RECOVER.
   always_ff @(posedge clk) begin
      if (!RST_N) begin
         r_state     <= IDLE;
         r_timer     <= 24'd0;
         r_errCnt    <= 8'd0;
         r_retry     <= 4'd0;
         r_faultCode <= 3'd0;
         r_lock      <= 1'b0;
         r_cciRun    <= 1'b0;
         r_csiEnable <= 1'b0;
         r_csiReset  <= 1'b1;
         r_streamOk  <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_timer     <= w_timerNext;
         r_errCnt    <= w_errNext;
         r_retry     <= w_retryNext;
         r_faultCode <= w_faultCodeNext;
         r_lock      <= w_lockNext;
         r_cciRun    <= w_cciRun;
         r_csiEnable <= w_csiEnable;
         r_csiReset  <= w_csiReset;
         r_streamOk  <= w_streamOk;
      end
   end

   assign bus.state      = r_state;
   assign bus.fault_code = r_faultCode;
   assign bus.fault_lock = r_lock;
   assign bus.cci_run    = r_cciRun;
   assign bus.csi_enable = r_csiEnable;
   assign bus.csi_reset  = r_csiReset;
   assign bus.stream_ok  = r_streamOk;

`ifdef CSI_BRINGUP_STATS_EN
   logic [15:0] r_pktGood, r_pktErr;
   logic        w_statWindow;

   assign w_statWindow = (r_state == ENABLE) || (r_state == STREAM);

   // Packet statistics: only pulses seen while the receiver is enabled are
   // counted, both counters stick at all-ones, and only reset clears them
   // so they survive fault recoveries.
   always_ff @(posedge clk) begin
      if (!RST_N) begin
         r_pktGood <= 16'd0;
         r_pktErr  <= 16'd0;
      end else if (w_statWindow) begin
         if (bus.csi_checksum_good && (r_pktGood != 16'hFFFF)) begin
            r_pktGood <= r_pktGood + 16'd1;
         end
         if (bus.csi_checksum_err && (r_pktErr != 16'hFFFF)) begin
            r_pktErr <= r_pktErr + 16'd1;
         end
      end
   end

   assign bus.pkt_good_cnt = r_pktGood;
   assign bus.pkt_err_cnt  = r_pktErr;
`else
   assign bus.pkt_good_cnt = 16'd0;
   assign bus.pkt_err_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_csi_bringup_seq.sv
// ---------------------------------------------------------------------------
// tb_csi_bringup_seq
// Purpose : self-checking bench for csi_bringup_seq. Small timeouts keep the
//           run short; RECOVER_CYCLES keeps its default of 1024.
// Build with CSI_BRINGUP_STATS_EN defined to cover the statistics counters.
// ---------------------------------------------------------------------------
module tb_csi_bringup_seq;

   localparam int INIT_T   = 20;
   localparam int STREAM_T = 30;
   localparam int ERR_L    = 16;
   localparam int REC      = 1024;
   localparam int MAXR     = 3;
`ifdef CSI_BRINGUP_STATS_EN
   localparam bit STATS    = 1'b1;
`else
   localparam bit STATS    = 1'b0;
`endif
   localparam int GOOD_N   = STATS ? 70000 : 300;

   logic clk   = 1'b0;
   logic RST_N = 1'b0;

   int nCompared   = 0;
   int nMismatch   = 0;
   int faultEntries = 0;
   int faultsBefore = 0;

   csi_bringup_seq_if bus();

   csi_bringup_seq #(
      .INIT_TIMEOUT   (24'(INIT_T)),
      .STREAM_TIMEOUT (24'(STREAM_T)),
      .ERR_LIMIT      (8'(ERR_L)),
      .RECOVER_CYCLES (16'(REC)),
      .MAX_RETRIES    (4'(MAXR))
   ) dut (
      .clk   (clk),
      .RST_N (RST_N),
      .bus   (bus)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Behavioural model of the sequencer, kept as plain integers: the state
   // number, how long it has been there, the current activity gap, the run
   // of checksum errors, retries used, last fault cause, lock flag and the
   // packet totals.
   int mState = 0;
   int mDwell = 0;
   int mGap   = 0;
   int mErr   = 0;
   int mRetry = 0;
   int mCode  = 0;
   int mGood  = 0;
   int mBad   = 0;
   bit mLock  = 1'b0;

   // Compare process. Inputs only change just after a rising edge, so at
   // the falling edge the DUT outputs reflect the last edge and the inputs
   // are exactly what the next edge will sample: compare first, then
   // advance the model by one clock using those inputs.
   initial begin
      logic [42:0] act, exp;
      int  nxt, code, e, prevState;
      bit  doneAll, anyErr, live;
      prevState = 0;
      forever begin
         @(negedge clk);
         live = (mState == 2) || (mState == 3);
         exp  = {(mState >= 1 && mState <= 3), live, !live, (mState == 3),
                 3'(mState), 3'(mCode), mLock, 16'(mGood), 16'(mBad)};
         act  = {bus.cci_run, bus.csi_enable, bus.csi_reset, bus.stream_ok,
                 bus.state, bus.fault_code, bus.fault_lock,
                 bus.pkt_good_cnt, bus.pkt_err_cnt};
         nCompared++;
         if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL model_cmp @%0t: actual=%h required=%h", $time, act, exp);
         end
         if (32'(bus.state) == 4 && prevState != 4) faultEntries++;
         prevState = 32'(bus.state);

         if (!RST_N) begin
            mState = 0; mDwell = 0; mGap = 0; mErr = 0; mRetry = 0;
            mCode = 0; mGood = 0; mBad = 0; mLock = 1'b0;
         end else begin
            doneAll = !bus.init_done_n && !bus.init_done0_n;
            anyErr  = !bus.init_error_n || !bus.init_error0_n;
            nxt  = mState;
            code = 0;
            e    = mErr;
            if (STATS && live) begin
               if (bus.csi_checksum_good) mGood = (mGood < 65535) ? mGood + 1 : 65535;
               if (bus.csi_checksum_err)  mBad  = (mBad  < 65535) ? mBad  + 1 : 65535;
            end
            case (mState)
               0: nxt = 1;
               1: begin
                  if (doneAll) nxt = 2;
                  else if (anyErr) code = 1;
                  else if (mDwell + 1 >= INIT_T) code = 2;
               end
               2: begin
                  if (bus.csi_raw_valid) nxt = 3;
                  else if (mGap + 1 >= STREAM_T) code = 3;
               end
               3: begin
                  if (bus.csi_checksum_err) e = (mErr < 255) ? mErr + 1 : 255;
                  else if (bus.csi_checksum_good) e = 0;
                  if (e >= ERR_L) code = 4;
                  else if (!bus.csi_raw_valid && mGap + 1 >= STREAM_T) code = 3;
               end
               4: begin
                  if (mRetry >= MAXR) mLock = 1'b1;
                  else begin
                     mRetry++;
                     nxt = 5;
                  end
               end
               default: if (mDwell + 1 >= REC) nxt = 1;
            endcase
            mErr = e;
            if (code != 0) begin
               nxt   = 4;
               mCode = code;
            end
            if (nxt == 3 && mState != 3) begin
               mRetry = 0;
               mErr   = 0;
            end
            mGap   = (bus.csi_raw_valid || nxt != mState) ? 0 : mGap + 1;
            mDwell = (nxt == mState) ? mDwell + 1 : 0;
            mState = nxt;
         end
      end
   end

   // Drive all status inputs, then let the given number of rising edges
   // pass and land just after the last one.
   task automatic applyStimulus(input logic doneN, input logic done0N,
                                input logic errN, input logic err0N,
                                input logic raw, input logic good,
                                input logic bad, input int cycles);
      bus.init_done_n       = doneN;
      bus.init_done0_n      = done0N;
      bus.init_error_n      = errN;
      bus.init_error0_n     = err0N;
      bus.csi_raw_valid     = raw;
      bus.csi_checksum_good = good;
      bus.csi_checksum_err  = bad;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatch++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   initial begin
      bus.init_done_n       = 1'b1;
      bus.init_done0_n      = 1'b1;
      bus.init_error_n      = 1'b1;
      bus.init_error0_n     = 1'b1;
      bus.csi_raw_valid     = 1'b0;
      bus.csi_checksum_good = 1'b0;
      bus.csi_checksum_err  = 1'b0;

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state",     32'(bus.state), 0);
      checkOutput("reset_cci_run",   32'(bus.cci_run), 0);
      checkOutput("reset_csi_reset", 32'(bus.csi_reset), 1);
      checkOutput("reset_csi_en",    32'(bus.csi_enable), 0);
      checkOutput("reset_fault_code",32'(bus.fault_code), 0);
      checkOutput("reset_lock",      32'(bus.fault_lock), 0);
      checkOutput("reset_good_cnt",  32'(bus.pkt_good_cnt), 0);
      RST_N = 1'b1;

      // Bring-up: IDLE for one cycle, WAIT_CCI, ENABLE, STREAM.
      $display("[TB] bring-up sequence");
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
      checkOutput("idle_to_wait",     32'(bus.state), 1);
      checkOutput("wait_cci_run",     32'(bus.cci_run), 1);
      checkOutput("wait_csi_reset",   32'(bus.csi_reset), 1);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 4);
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 1);
      checkOutput("wait_to_enable",   32'(bus.state), 2);
      checkOutput("enable_csi_en",    32'(bus.csi_enable), 1);
      checkOutput("enable_csi_reset", 32'(bus.csi_reset), 0);
      checkOutput("enable_stream_ok", 32'(bus.stream_ok), 0);
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 4);
      applyStimulus(0, 0, 1, 1, 1, 0, 0, 1);
      checkOutput("enable_to_stream", 32'(bus.state), 3);
      checkOutput("stream_ok",        32'(bus.stream_ok), 1);

      // 16 consecutive errors, the 8th with a simultaneous good pulse.
      $display("[TB] checksum error limit");
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(0, 0, 1, 1, 1, logic'(i == 8), 1, 1);
         if (i == 15) checkOutput("err15_no_fault", 32'(bus.state), 3);
      end
      checkOutput("err16_fault_state", 32'(bus.state), 4);
      checkOutput("err16_fault_code",  32'(bus.fault_code), 4);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
      checkOutput("fault_to_recover",  32'(bus.state), 5);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, REC);
      checkOutput("recover_to_wait",   32'(bus.state), 1);
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 1, 1, 0, 0, 1);
      checkOutput("restream",          32'(bus.state), 3);
      for (int i = 0; i < 31; i++) begin
         applyStimulus(0, 0, 1, 1, 1, logic'(i == 15), logic'(i != 15), 1);
      end
      checkOutput("err_broken_run_state", 32'(bus.state), 3);
      checkOutput("fault_code_held",      32'(bus.fault_code), 4);

      // Activity gap: 29 idle cycles are tolerated, the 30th faults.
      $display("[TB] stream gap timeout");
      applyStimulus(0, 0, 1, 1, 0, 0, 0, STREAM_T - 1);
      checkOutput("gap_minus1_state", 32'(bus.state), 3);
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 1);
      checkOutput("gap_fault_state",  32'(bus.state), 4);
      checkOutput("gap_fault_code",   32'(bus.fault_code), 3);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1 + REC);
      checkOutput("gap_recover_wait", 32'(bus.state), 1);

      // Init error on bus 0, then the exact RECOVER length.
      $display("[TB] init error and recover hold");
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 1);
      checkOutput("init_err_state", 32'(bus.state), 4);
      checkOutput("init_err_code",  32'(bus.fault_code), 1);
      checkOutput("fault_cci_run",  32'(bus.cci_run), 0);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
      checkOutput("init_err_recover", 32'(bus.state), 5);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, REC - 1);
      checkOutput("recover_last_cycle", 32'(bus.state), 5);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
      checkOutput("recover_done_state", 32'(bus.state), 1);
      checkOutput("recover_cci_run",    32'(bus.cci_run), 1);

      // Mid-sequence reset, then init timeouts until lock-out.
      $display("[TB] init timeout lock-out");
      RST_N = 1'b0;
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
      checkOutput("midrun_reset_state", 32'(bus.state), 0);
      RST_N = 1'b1;
      faultsBefore = faultEntries;
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, INIT_T - 1);
      checkOutput("init_timeout_minus1", 32'(bus.state), 1);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
      checkOutput("init_timeout_state", 32'(bus.state), 4);
      checkOutput("init_timeout_code",  32'(bus.fault_code), 2);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 3 * (1 + REC + INIT_T));
      checkOutput("fourth_fault_state", 32'(bus.state), 4);
      checkOutput("fourth_fault_unlock",32'(bus.fault_lock), 0);
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
      checkOutput("lock_set", 32'(bus.fault_lock), 1);
      applyStimulus(0, 0, 1, 1, 1, 0, 0, 50);
      checkOutput("lock_frozen_state", 32'(bus.state), 4);
      checkOutput("lock_held",         32'(bus.fault_lock), 1);
      checkOutput("lock_code",         32'(bus.fault_code), 2);
      checkOutput("lock_fault_count",  32'(faultEntries - faultsBefore), 4);
      RST_N = 1'b0;
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
      checkOutput("lock_reset_state", 32'(bus.state), 0);
      checkOutput("lock_reset_lock",  32'(bus.fault_lock), 0);
      RST_N = 1'b1;

      // Statistics: good pulses from ENABLE onward, then a few errors.
      $display("[TB] statistics counters");
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 1, 1, 1, 0, 1);
      applyStimulus(0, 0, 1, 1, 1, 1, 0, GOOD_N - 1);
      applyStimulus(0, 0, 1, 1, 1, 0, 1, 3);
      applyStimulus(0, 0, 1, 1, 1, 0, 0, 1);
      checkOutput("stats_state",    32'(bus.state), 3);
      checkOutput("stats_good_cnt", 32'(bus.pkt_good_cnt), STATS ? 65535 : 0);
      checkOutput("stats_err_cnt",  32'(bus.pkt_err_cnt),  STATS ? 3 : 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/csi_bringup_seq.md
CSI_BRINGUP_SEQ -- requirements
Module: csi_bringup_seq

Interface
REQ-001 SHALL have parameter INIT_TIMEOUT, default 24'd12_000_000, max clk cycles in WAIT_CCI before fault.
REQ-002 SHALL have parameter STREAM_TIMEOUT, default 24'd6_000_000, max clk cycles without csi_raw_valid in ENABLE/STREAM.
REQ-003 SHALL have parameter ERR_LIMIT, default 8'd16, consecutive checksum errors that trigger a fault.
REQ-004 SHALL have parameter RECOVER_CYCLES, default 16'd1024, length of the RECOVER hold.
REQ-005 SHALL have parameter MAX_RETRIES, default 4'd3, recoveries allowed before lock-out.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 RST_N  input  1  synchronous, active-low reset.
REQ-008 init_done_n, init_done0_n  input  1 each  CCI init complete, active-low, one per sensor bus.
REQ-009 init_error_n, init_error0_n  input  1 each  CCI init error, active-low.
REQ-010 csi_raw_valid, csi_checksum_good, csi_checksum_err  input  1 each  RX activity/packet-status pulses, already synchronous to clk.
REQ-011 cci_run  output  1  high lets both CCI handlers run; low holds them in reset.
REQ-012 csi_enable  output  1  CSI RX enable.
REQ-013 csi_reset  output  1  CSI RX reset, active-high.
REQ-014 stream_ok  output  1  high while in STREAM.
REQ-015 state  output  3  current state encoding.
REQ-016 fault_code  output  3  cause of most recent fault.
REQ-017 fault_lock  output  1  retries exhausted.
REQ-018 pkt_good_cnt, pkt_err_cnt  output  16 each  statistics counters.

Function
REQ-019 States SHALL be IDLE=0, WAIT_CCI=1, ENABLE=2, STREAM=3, FAULT=4, RECOVER=5.
REQ-020 IDLE SHALL last exactly one cycle, then go to WAIT_CCI with the timer cleared.
REQ-021 In WAIT_CCI: cci_run=1, csi_enable=0, csi_reset=1.
REQ-021a In WAIT_CCI, both init_done_n low SHALL go to ENABLE.
REQ-021b In WAIT_CCI, otherwise either init_error_n low SHALL go to FAULT with code 1; otherwise the timer reaching INIT_TIMEOUT SHALL go to FAULT with code 2.
REQ-022 In ENABLE: cci_run=1, csi_enable=1, csi_reset=0.
REQ-022a In ENABLE, the first csi_raw_valid SHALL go to STREAM.
REQ-022b In ENABLE, the timer reaching STREAM_TIMEOUT SHALL go to FAULT with code 3.
REQ-023 In STREAM: outputs SHALL be as in ENABLE, with stream_ok=1.
REQ-023a In STREAM, the gap timer SHALL clear on every csi_raw_valid; the gap timer reaching STREAM_TIMEOUT SHALL go to FAULT with code 3.
REQ-024 In STREAM, consecutive-error counter (8 bit, saturating) handling:
- csi_checksum_err SHALL increment it.
- csi_checksum_good alone SHALL clear it.
- Both asserted in the same cycle: increment, no clear.
- Reaching ERR_LIMIT SHALL go to FAULT with code 4.
REQ-025 Fault priority in a single cycle SHALL be: error code 1 > 4 > 3 > 2.
REQ-026 FAULT SHALL last one cycle with cci_run=0, csi_enable=0, csi_reset=1.
REQ-026a On FAULT, if retry count equals MAX_RETRIES, SHALL remain in FAULT with fault_lock=1 until reset.
REQ-026b On FAULT otherwise, SHALL increment the retry count and go to RECOVER.
REQ-027 RECOVER SHALL hold cci_run=0, csi_enable=0, csi_reset=1 for exactly RECOVER_CYCLES cycles, then enter WAIT_CCI with timers cleared.
REQ-028 Entering STREAM SHALL clear the retry count and the error counter.
REQ-029 fault_code SHALL update only on entry to FAULT and hold otherwise.
REQ-030 All outputs SHALL be registered; state transitions take effect one cycle after the qualifying input.
REQ-031 Timers SHALL be 24 bit and SHALL NOT wrap (compare-equal ends the state).

Reset
REQ-032 RST_N low at any clk edge, including mid-RECOVER or while locked, SHALL force state IDLE and clear all counters.
REQ-032a Reset output values: cci_run=0, csi_enable=0, csi_reset=1, stream_ok=0, fault_code=0, fault_lock=0, pkt counters=0.

Configuration
REQ-033 With macro CSI_BRINGUP_STATS_EN defined: pkt_good_cnt/pkt_err_cnt SHALL count csi_checksum_good/err pulses in ENABLE and STREAM, saturating at 16'hFFFF, and SHALL be cleared only by reset.
REQ-034 Without CSI_BRINGUP_STATS_EN: both counter outputs SHALL be constant 0, with no counter logic.

Verification
REQ-035 Reset, both init_done_n low at cycle 5, raw_valid at cycle 10 -> state sequence 0,1,2,3; stream_ok=1 one cycle after raw_valid.
REQ-036 init_error0_n low in WAIT_CCI -> FAULT with fault_code=1, then RECOVER for 1024 cycles, then WAIT_CCI with cci_run=1.
REQ-037 In STREAM, 16 checksum_err pulses with one simultaneous good pulse -> FAULT code 4 on the 16th; then 15 errors, 1 good, 15 errors -> no fault.
REQ-038 init_done_n held high -> 4 faults (code 2), fault_lock=1, state frozen at 4; RST_N low for 1 cycle -> IDLE, fault_lock=0.
REQ-039 With CSI_BRINGUP_STATS_EN: 70000 good pulses -> pkt_good_cnt=16'hFFFF; without it -> 0.
